dyser_send_queue: RTL and testbench

//  Upstream of the dyser array: buffers dual-lane dyser_send requests from the core pipeline.

---
 rtl/dyser_send_queue_pkg.sv | 39 +++
 rtl/dyser_send_fifo.sv | 43 ++++
 rtl/dyser_send_queue.sv | 85 ++++++++
 tb/tb_dyser_send_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dyser_send_queue_pkg.sv
// Shared dyser config and send-queue types.
// Entry layout is common to the queue and the dyser-side consumer.
`ifndef DYSER_CONFIG_DEFS
`define DYSER_CONFIG_DEFS
`define DATA_WIDTH 8
`define DYSER_PORT_W 3
`define DYSER_SEND_ENTRY_W (2*(1+`DYSER_PORT_W+`DATA_WIDTH+1))
`endif

package dyser_send_queue_pkg;
  localparam int DEPTH   = 4;
  localparam int PTR_W   = 2;
  localparam int DW      = `DATA_WIDTH + 1;
  localparam int PORT_W  = `DYSER_PORT_W;
  localparam int ENTRY_W = `DYSER_SEND_ENTRY_W;

  typedef struct packed {
    logic              v;
    logic [PORT_W-1:0] port;
    logic [DW-1:0]     data;
  } lane_t;

  typedef struct packed {
    lane_t l0;
    lane_t l1;
  } entry_t;

  function automatic lane_t mk_lane(
    input logic              v,
    input logic [PORT_W-1:0] port,
    input logic [DW-1:0]     data
  );
    lane_t l;
    l.v    = v;
    l.port = port;
    l.data = data;
    return l;
  endfunction
endpackage

// File: rtl/dyser_send_fifo.sv
// Generic synchronous FIFO with flush.
// Caller must not push when full or pop when empty.
module dyser_send_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_flush,
  input  logic           i_push,
  input  logic [W-1:0]   i_data,
  input  logic           i_pop,
  output logic [W-1:0]   o_head,
  output logic [PTR_W:0] o_count
);
  logic [W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  // storage write; contents after flush are don't-care
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // pointers and occupancy; flush/reset dominate push and pop
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/dyser_send_queue.sv
// Dual-lane dyser send queue between the core and the dyser array.
// Absorbs send_stall back-pressure while there is room.
module dyser_send_queue
  import dyser_send_queue_pkg::*;
#(
  parameter int QDEPTH = DEPTH,
  parameter int QPTR_W = PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid0,
  input  logic [PORT_W-1:0] in_port0,
  input  logic [DW-1:0]     in_data0,
  input  logic              in_valid1,
  input  logic [PORT_W-1:0] in_port1,
  input  logic [DW-1:0]     in_data1,
  output logic              in_ready,
  output logic              send_en0,
  output logic [PORT_W-1:0] send_port_r0,
  output logic [DW-1:0]     send_data_r0,
  output logic              send_en1,
  output logic [PORT_W-1:0] send_port_r1,
  output logic [DW-1:0]     send_data_r1,
  input  logic              send_stall,
  output logic [QPTR_W:0]   count,
  output logic              overflow_err
);
  entry_t          w_in;
  entry_t          w_head;
  entry_t          w_out;
  logic            w_req;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [QPTR_W:0] w_count;
  logic            r_ovf;

  assign w_in.l0 = mk_lane(in_valid0, in_port0, in_data0);
  assign w_in.l1 = mk_lane(in_valid1, in_port1, in_data1);

  assign w_req   = in_valid0 | in_valid1;
  assign w_full  = (w_count == (QPTR_W+1)'(QDEPTH));
  assign w_empty = (w_count == '0);
  assign w_push  = !w_full & w_req & !flush;
  assign w_pop   = !w_empty & !send_stall & !flush;

  dyser_send_fifo #(
    .DEPTH (QDEPTH),
    .W     (ENTRY_W),
    .PTR_W (QPTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // sticky drop flag; only reset clears it
  always_ff @(posedge clk) begin
    if (rst)                  r_ovf <= 1'b0;
    else if (w_req && w_full) r_ovf <= 1'b1;
  end

  // head is hidden entirely while the queue is empty
  always_comb begin
    w_out = '0;
    if (!w_empty) w_out = w_head;
  end

  assign in_ready     = !w_full;
  assign send_en0     = w_out.l0.v;
  assign send_port_r0 = w_out.l0.port;
  assign send_data_r0 = w_out.l0.data;
  assign send_en1     = w_out.l1.v;
  assign send_port_r1 = w_out.l1.port;
  assign send_data_r1 = w_out.l1.data;
  assign count        = w_count;
  assign overflow_err = r_ovf;
endmodule

// File: tb/tb_dyser_send_queue.sv
// Directed self-checking bench for dyser_send_queue.
// Inputs driven 1ns after posedge, outputs sampled there.
module tb_dyser_send_queue;
  import dyser_send_queue_pkg::*;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              in_valid0, in_valid1;
  logic [PORT_W-1:0] in_port0, in_port1;
  logic [DW-1:0]     in_data0, in_data1;
  logic              in_ready;
  logic              send_en0, send_en1;
  logic [PORT_W-1:0] send_port_r0, send_port_r1;
  logic [DW-1:0]     send_data_r0, send_data_r1;
  logic              send_stall;
  logic [PTR_W:0]    count;
  logic              overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dyser_send_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid0    (in_valid0),
    .in_port0     (in_port0),
    .in_data0     (in_data0),
    .in_valid1    (in_valid1),
    .in_port1     (in_port1),
    .in_data1     (in_data1),
    .in_ready     (in_ready),
    .send_en0     (send_en0),
    .send_port_r0 (send_port_r0),
    .send_data_r0 (send_data_r0),
    .send_en1     (send_en1),
    .send_port_r1 (send_port_r1),
    .send_data_r1 (send_data_r1),
    .send_stall   (send_stall),
    .count        (count),
    .overflow_err (overflow_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input int p0, input int d0,
                       input logic v1, input int p1, input int d1);
    in_valid0 = v0; in_port0 = PORT_W'(p0); in_data0 = DW'(d0);
    in_valid1 = v1; in_port1 = PORT_W'(p1); in_data1 = DW'(d1);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; send_stall = 0; idle();
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({in_ready, count, send_en0, send_en1, overflow_err} !== {1'b1, 3'd0, 3'b000}) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got rdy=%b cnt=%0d en=%b%b ovf=%b exp 1 0 00 0",
                 c, in_ready, count, send_en0, send_en1, overflow_err);
      end
      checks++;
      if ({send_port_r0, send_data_r0, send_port_r1, send_data_r1} !== '0) begin
        errors++;
        $display("FAIL reset_zero got p0=%0d d0=%0h p1=%0d d1=%0h exp all 0",
                 send_port_r0, send_data_r0, send_port_r1, send_data_r1);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b1, 5, 'h0, 1'b1, 3, 'h1);
    tick();
    idle();
    checks++;
    if ({send_en0, send_port_r0, send_data_r0, send_en1, send_port_r1, send_data_r1, count}
        !== {1'b1, 3'd5, 9'h0, 1'b1, 3'd3, 9'h1, 3'd1}) begin
      errors++;
      $display("FAIL single_head got en%b p%0d d%0h en%b p%0d d%0h c%0d exp 1 5 0 1 3 1 c1",
               send_en0, send_port_r0, send_data_r0,
               send_en1, send_port_r1, send_data_r1, count);
    end
    tick();
    checks++;
    if ({count, send_en0, send_en1} !== {3'd0, 2'b00}) begin
      errors++;
      $display("FAIL single_retire got cnt=%0d en=%b%b exp 0 00", count, send_en0, send_en1);
    end
  endtask

  task automatic test_stall();
    int p0 [5] = '{5, 7, 2, 6, 4};
    int d0 [5] = '{'ha, 'hf, 'h11, 'h33, 'h1ff};
    int p1 [5] = '{3, 1, 4, 0, 2};
    int d1 [5] = '{'hf, 'h5, 'h22, 'h44, 'h100};
    send_stall = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, p0[i], d0[i], 1'b1, p1[i], d1[i]);
      tick();
      checks++;
      if ({send_port_r0, send_data_r0, send_port_r1, send_data_r1, count}
          !== {3'd5, 9'ha, 3'd3, 9'hf, 3'(i+1)}) begin
        errors++;
        $display("FAIL stall_hold%0d got p%0d d%0h p%0d d%0h c%0d exp 5 a 3 f c%0d",
                 i, send_port_r0, send_data_r0, send_port_r1, send_data_r1, count, i+1);
      end
    end
    idle();
    #1;
    checks++;
    if ({in_ready, overflow_err} !== 2'b00) begin
      errors++;
      $display("FAIL stall_full got rdy=%b ovf=%b exp 0 0", in_ready, overflow_err);
    end
    drive(1'b1, p0[4], d0[4], 1'b1, p1[4], d1[4]);
    tick();
    idle();
    checks++;
    if ({overflow_err, count} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL stall_ovf got ovf=%b cnt=%0d exp 1 4", overflow_err, count);
    end
    send_stall = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({send_en0, send_port_r0, send_data_r0, send_en1, send_port_r1, send_data_r1, count}
          !== {1'b1, 3'(p0[i]), 9'(d0[i]), 1'b1, 3'(p1[i]), 9'(d1[i]), 3'(4-i)}) begin
        errors++;
        $display("FAIL drain%0d got p%0d d%0h p%0d d%0h c%0d exp p%0d d%0h p%0d d%0h c%0d",
                 i, send_port_r0, send_data_r0, send_port_r1, send_data_r1, count,
                 p0[i], d0[i], p1[i], d1[i], 4-i);
      end
      tick();
    end
    checks++;
    if ({count, in_ready, send_en0, send_en1} !== {3'd0, 3'b100}) begin
      errors++;
      $display("FAIL drain_end got cnt=%0d rdy=%b en=%b%b exp 0 1 00",
               count, in_ready, send_en0, send_en1);
    end
  endtask

  task automatic test_lane1();
    drive(1'b0, 0, 0, 1'b1, 1, 'h3);
    tick();
    idle();
    checks++;
    if ({send_en0, send_en1, send_port_r1, send_data_r1, count}
        !== {1'b0, 1'b1, 3'd1, 9'h3, 3'd1}) begin
      errors++;
      $display("FAIL lane1 got en%b%b p1=%0d d1=%0h c%0d exp 01 1 3 c1",
               send_en0, send_en1, send_port_r1, send_data_r1, count);
    end
    tick();
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL lane1_retire got cnt=%0d exp 0", count);
    end
  endtask

  task automatic test_back_to_back();
    send_stall = 1;
    for (int s = 0; s < 2; s++) begin
      drive(1'b1, s % 8, s, 1'b1, (s + 3) % 8, s + 100);
      tick();
    end
    send_stall = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i + 2) % 8, i + 2, 1'b1, (i + 5) % 8, i + 102);
      tick();
      checks++;
      if ({count, send_port_r0, send_data_r0, send_data_r1}
          !== {3'd2, 3'((i + 1) % 8), 9'(i + 1), 9'(i + 101)}) begin
        errors++;
        $display("FAIL pushpop%0d got c%0d p0=%0d d0=%0d d1=%0d exp c2 p0=%0d d0=%0d d1=%0d",
                 i, count, send_port_r0, send_data_r0, send_data_r1,
                 (i + 1) % 8, i + 1, i + 101);
      end
    end
    idle();
    tick();
    checks++;
    if ({count, send_data_r0} !== {3'd1, 9'd11}) begin
      errors++;
      $display("FAIL pushpop_tail got c%0d d0=%0d exp c1 d0=11", count, send_data_r0);
    end
    tick();
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL pushpop_empty got cnt=%0d exp 0", count);
    end
  endtask

  task automatic test_flush();
    send_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i, i + 'h40, 1'b0, 0, 0);
      tick();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre got cnt=%0d exp 3", count);
    end
    flush = 1;
    drive(1'b1, 6, 'h77, 1'b1, 7, 'h88);
    tick();
    flush = 0;
    idle();
    checks++;
    if ({count, send_en0, send_en1, in_ready} !== {3'd0, 3'b001}) begin
      errors++;
      $display("FAIL flush got cnt=%0d en=%b%b rdy=%b exp 0 00 1",
               count, send_en0, send_en1, in_ready);
    end
    send_stall = 0;
    tick();
    checks++;
    if ({count, send_en0, send_en1, overflow_err} !== {3'd0, 3'b001}) begin
      errors++;
      $display("FAIL flush_after got cnt=%0d en=%b%b ovf=%b exp 0 00 1",
               count, send_en0, send_en1, overflow_err);
    end
    send_stall = 1;
    drive(1'b1, 2, 'h5, 1'b0, 0, 0);
    tick();
    rst = 1;
    idle();
    tick();
    rst = 0;
    send_stall = 0;
    checks++;
    if ({overflow_err, count, in_ready, send_en0} !== {1'b0, 3'd0, 2'b10}) begin
      errors++;
      $display("FAIL midrst got ovf=%b cnt=%0d rdy=%b en0=%b exp 0 0 1 0",
               overflow_err, count, in_ready, send_en0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_lane1();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
